// File: rtl/uart_pkg.sv
// Shared UART-path types: serializer FSM encoding and frame-size derivation.
// Pure declarations, no logic.
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   // Bytes per frame: R lanes of w_y_out bits, cut into w_byte-wide words.
   function automatic int calc_n_bytes(input int r, input int w_y_out, input int w_byte);
      return (r * w_y_out) / w_byte;
   endfunction

   // Default frame size for R=8, W_Y_OUT=32, W_BYTE=8.
   localparam int N_BYTES_DEFAULT = calc_n_bytes(8, 32, 8);

endpackage

// File: rtl/axis_y_serializer.sv
// Splits one word of R signed lanes into a little-endian byte stream, lane 0 first.
// Byte 0 appears 1 cycle after accept; m_ready=0 freezes the byte, and a new word loads on the last-byte handshake.
module axis_y_serializer
   import uart_pkg::*;
#(
   parameter int R       = 8,
   parameter int W_Y     = 19,
   parameter int W_Y_OUT = 32,
   parameter int W_BYTE  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [R*W_Y-1:0]    s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [W_BYTE-1:0]   m_data,
   output logic                m_last
);

   localparam int N_BYTES = calc_n_bytes(R, W_Y_OUT, W_BYTE);
   localparam int CW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int SW      = R * W_Y_OUT;

   localparam logic [CW-1:0] CNT_LAST = CW'(N_BYTES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   ser_state_t        state;
   logic [SW-1:0]     shreg;
   logic [SW-1:0]     ext;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;
   logic              s_hs;
   logic              m_hs;

   // Each lane is widened by replicating its sign bit into the upper bits.
   for (genvar r = 0; r < R; r++) begin : g_sext
      if (W_Y_OUT > W_Y) begin : g_pad
         assign ext[r*W_Y_OUT +: W_Y_OUT] =
            {{(W_Y_OUT-W_Y){s_data[W_Y*(r+1)-1]}}, s_data[W_Y*r +: W_Y]};
      end else begin : g_nopad
         assign ext[r*W_Y_OUT +: W_Y_OUT] = s_data[W_Y*r +: W_Y];
      end
   end

   // Readiness follows m_ready combinationally so the next word can slide in behind the last byte.
   assign s_ready = (state == IDLE) || (m_last && m_ready);
   assign s_hs    = s_valid && s_ready;
   assign m_hs    = m_valid && m_ready;
   assign m_data  = shreg[W_BYTE-1:0];
   assign cnt_nxt = cnt + CNT_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s_hs) begin
                  shreg   <= ext;
                  cnt     <= '0;
                  state   <= SEND;
                  m_valid <= 1'b1;
                  m_last  <= (N_BYTES == 1);
               end
            end
            SEND: begin
               if (m_hs) begin
                  if (m_last) begin
                     if (s_hs) begin
                        shreg  <= ext;
                        cnt    <= '0;
                        m_last <= (N_BYTES == 1);
                     end else begin
                        shreg   <= shreg >> W_BYTE;
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                     end
                  end else begin
                     shreg  <= shreg >> W_BYTE;
                     cnt    <= cnt_nxt;
                     m_last <= (cnt_nxt == CNT_LAST);
                  end
               end
            end
            default: begin
               state   <= IDLE;
               m_valid <= 1'b0;
               m_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_y_serializer.sv
// Scoreboard bench for axis_y_serializer: expected bytes queued at word accept, compared per byte handshake.
module tb_axis_y_serializer;

   localparam int R       = 8;
   localparam int W_Y     = 19;
   localparam int W_Y_OUT = 32;
   localparam int W_BYTE  = 8;
   localparam int NB      = R * W_Y_OUT / W_BYTE;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [R*W_Y-1:0]    s_data = '0;
   logic                m_valid;
   logic                m_ready = 1'b1;
   logic [W_BYTE-1:0]   m_data;
   logic                m_last;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_popped = 0;
   bit   stall_en = 1'b0;
   logic [8:0] sb[$];

   axis_y_serializer #(.R(R), .W_Y(W_Y), .W_Y_OUT(W_Y_OUT), .W_BYTE(W_BYTE)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      if (stall_en) m_ready = ($urandom_range(0, 99) >= 30);
   end

   // Scoreboard consumer: every accepted byte must match the front of the queue.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: got byte %02h last %0b, expected none", m_data, m_last);
         end else begin
            logic [8:0] exp;
            exp = sb.pop_front();
            if ({m_last, m_data} !== exp) begin
               n_bad++;
               $display("FAIL byte[%0d]: got %02h last %0b, expected %02h last %0b",
                        n_popped, m_data, m_last, exp[7:0], exp[8]);
            end
         end
         n_popped++;
      end
   end

   function automatic logic [R*W_Y-1:0] make_word(input int v0, input int vr, input bit incr);
      logic [R*W_Y-1:0] w;
      for (int r = 0; r < R; r++)
         w[r*W_Y +: W_Y] = incr ? W_Y'(r + 1) : ((r == 0) ? W_Y'(v0) : W_Y'(vr));
      return w;
   endfunction

   function automatic void push_word(input logic [R*W_Y-1:0] d);
      for (int r = 0; r < R; r++) begin
         logic signed [W_Y-1:0] lane;
         longint v;
         lane = d[r*W_Y +: W_Y];
         v = lane;
         for (int b = 0; b < W_Y_OUT/8; b++) begin
            logic [7:0] by;
            by = 8'((v >>> (8*b)) & 255);
            sb.push_back({(r == R-1) && (b == W_Y_OUT/8-1), by});
         end
      end
   endfunction

   // Entered and left at posedge+1; s_valid stays high on return.
   task automatic offer(input logic [R*W_Y-1:0] d);
      bit acc;
      acc = 1'b0;
      s_data = d;
      s_valid = 1'b1;
      for (int i = 0; i < 3000 && !acc; i++) begin
         @(negedge clk);
         if (s_ready) begin
            push_word(d);
            acc = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: s_ready never seen, required 1");
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !m_valid) done = 1'b1;
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d bytes outstanding, m_valid %0b, required 0/0", sb.size(), m_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({m_valid, m_last, m_data} !== 10'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got valid %0b last %0b data %02h, required 0 0 00", m_valid, m_last, m_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL ready_after_reset: got s_ready %0b m_valid %0b, required 1 0", s_ready, m_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_all_fives();
      m_ready = 1'b1;
      offer(make_word(5, 5, 1'b0));
      s_valid = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'h05 || m_last !== 1'b0) begin
         n_bad++;
         $display("FAIL first_byte_latency: got valid %0b data %02h last %0b, required 1 05 0", m_valid, m_data, m_last);
      end
      wait_drain();
   endtask

   task automatic test_pattern(input int v0, input int vr);
      m_ready = 1'b1;
      offer(make_word(v0, vr, 1'b0));
      s_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_stall();
      bit prev_stall, done;
      logic [7:0] prev_d;
      logic prev_l;
      stall_en = 1'b1;
      offer(make_word(0, 0, 1'b1));
      s_valid = 1'b0;
      prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0; done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (prev_stall) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
               n_bad++;
               $display("FAIL stall_hold: got valid %0b data %02h last %0b, required 1 %02h %0b",
                        m_valid, m_data, m_last, prev_d, prev_l);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_d = m_data;
         prev_l = m_last;
         if (sb.size() == 0 && !m_valid) done = 1'b1;
      end
      stall_en = 1'b0;
      m_ready = 1'b1;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL stall_timeout: %0d bytes outstanding, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int gaps, rdy_cnt, rdy_idx;
      bit seen;
      m_ready = 1'b1;
      gaps = 0; rdy_cnt = 0; rdy_idx = -1; seen = 1'b0;
      fork
         begin
            offer(make_word(3, 7, 1'b0));
            offer(make_word(-2, 9, 1'b0));
            s_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge clk);
               if (m_valid) seen = 1'b1;
            end
            if (seen) begin
               for (int k = 0; k < 2*NB; k++) begin
                  if (k > 0) @(negedge clk);
                  if (!m_valid) gaps++;
                  if (k < 2*NB-1 && s_ready) begin
                     rdy_cnt++;
                     rdy_idx = k;
                  end
               end
               @(negedge clk);
            end
         end
      join
      n_cmp++;
      if (!seen || gaps != 0) begin
         n_bad++;
         $display("FAIL b2b_gaps: got %0d gaps (started %0b), required 0", gaps, seen);
      end
      n_cmp++;
      if (rdy_cnt != 1 || rdy_idx != NB-1) begin
         n_bad++;
         $display("FAIL b2b_s_ready: got %0d pulses last at byte %0d, required 1 at byte %0d", rdy_cnt, rdy_idx, NB-1);
      end
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_end: got m_valid %0b after 64 bytes, required 0", m_valid);
      end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b1;
      offer(make_word(11, 12, 1'b0));
      s_valid = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0 || m_data !== 8'h00) begin
         n_bad++;
         $display("FAIL mid_reset: got m_valid %0b data %02h, required 0 00", m_valid, m_data);
      end
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_resume: got m_valid %0b, required 0", m_valid);
         end
      end
      @(posedge clk);
      #1;
      offer(make_word(-100, 4, 1'b0));
      s_valid = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b1 || sb.size() == 0 || m_data !== sb[0][7:0]) begin
         n_bad++;
         $display("FAIL post_reset_byte0: got valid %0b data %02h, required 1 9c", m_valid, m_data);
      end
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_all_fives();
      test_pattern(-1, 0);
      test_pattern(262143, 0);
      test_pattern(-262144, 1);
      test_stall();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (n_popped < 5*NB) begin
         n_bad++;
         $display("FAIL byte_count: got %0d bytes, required at least %0d", n_popped, 5*NB);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
